// File: rtl/data_ram_wait_pkg.sv
// Shared bus widths and enable encodings for the data-memory port.
// Imported by the RAM responder, its storage array and its bus interface.
package data_ram_wait_pkg;

    localparam int DATA_BUS_W      = 32;
    localparam int DATA_ADDR_BUS_W = 32;
    localparam int BYTE_SEL_BUS_W  = 4;

    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b0;
    localparam logic CHIP_ENABLE  = 1'b1;

endpackage

// File: rtl/data_ram_wait_if.sv
// Core data-port bus: the core is the master, the data RAM is the slave.
interface data_ram_wait_if;
    import data_ram_wait_pkg::*;

    logic                       ce;
    logic                       we;
    logic [DATA_ADDR_BUS_W-1:0] addr;
    logic [BYTE_SEL_BUS_W-1:0]  sel;
    logic [DATA_BUS_W-1:0]      data_i;
    logic [DATA_BUS_W-1:0]      data_o;
    logic                       ack_o;
    logic                       stallreq_o;

    modport master (
        output ce, we, addr, sel, data_i,
        input  data_o, ack_o, stallreq_o
    );

    modport slave (
        input  ce, we, addr, sel, data_i,
        output data_o, ack_o, stallreq_o
    );

endinterface

// File: rtl/data_ram_wait_array.sv
// Byte-lane writable word storage with a registered read port.
// The read register returns zero in any cycle that did not follow a read.
module data_ram_array
    import data_ram_wait_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [DEPTH_LOG2-1:0]     word_addr,
    input  logic [BYTE_SEL_BUS_W-1:0] sel,
    input  logic [DATA_BUS_W-1:0]     wdata,
    output logic [DATA_BUS_W-1:0]     rdata
);

    logic [DATA_BUS_W-1:0] mem_r [0:(1 << DEPTH_LOG2) - 1];
    logic [DATA_BUS_W-1:0] rdata_r;

    // per-lane write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTE_SEL_BUS_W; i++) begin
            if (wr_en && sel[i]) begin
                mem_r[word_addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // read register, cleared when no read was issued on this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (rd_en) begin
            rdata_r <= mem_r[word_addr];
        end else begin
            rdata_r <= 32'h0000_0000;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_ram_wait.sv
// Data-memory responder: latches one request, inserts WAIT_CYCLES busy
// cycles while stalling the pipeline, then performs the access and acks.
module data_ram_wait
    import data_ram_wait_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_LOG2  = 10
) (
    input  logic           clk,
    input  logic           rst,
    data_ram_wait_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_ACK  = 2'b10
    } state_t;

    localparam int   CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic ZERO_WAIT = (WAIT_CYCLES == 0) ? 1'b1 : 1'b0;

    state_t                    state_r;
    state_t                    state_s;
    logic [CNT_W-1:0]          cnt_r;
    logic                      we_r;
    logic [DEPTH_LOG2-1:0]     addr_r;
    logic [BYTE_SEL_BUS_W-1:0] sel_r;
    logic [DATA_BUS_W-1:0]     wdata_r;
    logic                      ack_r;

    logic                      request_s;
    logic                      access_s;
    logic                      acc_we_s;
    logic [DEPTH_LOG2-1:0]     acc_addr_s;
    logic [BYTE_SEL_BUS_W-1:0] acc_sel_s;
    logic [DATA_BUS_W-1:0]     acc_wdata_s;
    logic                      wr_en_s;
    logic                      rd_en_s;
    logic [DATA_BUS_W-1:0]     rdata_s;
    logic                      addr_unused_s;

    assign request_s     = (bus.ce == CHIP_ENABLE);
    // byte offset and bits above the array size are don't-care (address wraps)
    assign addr_unused_s = ^{bus.addr[DATA_ADDR_BUS_W-1:DEPTH_LOG2+2], bus.addr[1:0]};

    // next state, access strobe and source of the access (live in IDLE, latched after)
    always_comb begin
        state_s     = state_r;
        access_s    = 1'b0;
        acc_we_s    = we_r;
        acc_addr_s  = addr_r;
        acc_sel_s   = sel_r;
        acc_wdata_s = wdata_r;
        case (state_r)
            ST_IDLE: begin
                acc_we_s    = bus.we;
                acc_addr_s  = bus.addr[DEPTH_LOG2+1:2];
                acc_sel_s   = bus.sel;
                acc_wdata_s = bus.data_i;
                if (request_s && ZERO_WAIT) begin
                    access_s = 1'b1;
                    state_s  = ST_ACK;
                end else if (request_s) begin
                    state_s  = ST_BUSY;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == LAST_CNT) begin
                    access_s = 1'b1;
                    state_s  = ST_ACK;
                end else begin
                    state_s  = ST_BUSY;
                end
            end
            ST_ACK:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // state, wait counter, request latch and ack strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            sel_r   <= 4'h0;
            wdata_r <= 32'h0000_0000;
            ack_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            ack_r   <= (state_s == ST_ACK);
            if (state_r == ST_IDLE && request_s) begin
                cnt_r   <= '0;
                we_r    <= bus.we;
                addr_r  <= bus.addr[DEPTH_LOG2+1:2];
                sel_r   <= bus.sel;
                wdata_r <= bus.data_i;
            end else if (state_r == ST_BUSY) begin
                cnt_r   <= cnt_r + CNT_W'(1);
            end
        end
    end

    // reset on the access edge suppresses the write
    assign wr_en_s = access_s && (acc_we_s == WRITE_ENABLE) && !rst;
    assign rd_en_s = access_s && (acc_we_s == READ_ENABLE) && !rst;

    data_ram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en_s),
        .rd_en     (rd_en_s),
        .word_addr (acc_addr_s),
        .sel       (acc_sel_s),
        .wdata     (acc_wdata_s),
        .rdata     (rdata_s)
    );

    assign bus.data_o     = rdata_s;
    assign bus.ack_o      = ack_r;
    assign bus.stallreq_o = !rst && (((state_r == ST_IDLE) && request_s) || (state_r == ST_BUSY));

endmodule
